// File: rtl/multiword_add_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : multiword_add_seq_if
//  Description : Operand, result and nibble-adder signals for the
//                multi-word add sequencer.
//                slave  = the sequencer
//                master = its environment (producer, consumer, 4-bit adder)
//  Revision    : 1.0  initial release
// ============================================================================
interface multiword_add_seq_if #(
    parameter int WIDTH = 16
);
    // Operand request
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;

    // Nibble adder
    logic [3:0]       add_a;
    logic [3:0]       add_b;
    logic             add_cin;
    logic [3:0]       add_sum;
    logic             add_cout;

    // Result
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             busy;

    modport slave (
        input  in_valid, in_a, in_b, in_cin, add_sum, add_cout, out_ready,
        output in_ready, add_a, add_b, add_cin, out_valid, out_sum, out_cout, busy
    );

    modport master (
        output in_valid, in_a, in_b, in_cin, add_sum, add_cout, out_ready,
        input  in_ready, add_a, add_b, add_cin, out_valid, out_sum, out_cout, busy
    );
endinterface
`default_nettype wire

// File: rtl/multiword_add_seq.sv
`default_nettype none
// ============================================================================
//  Module      : multiword_add_seq
//  Description : WIDTH-bit adder built by stepping an external 4-bit
//                ripple-carry adder one nibble per cycle, LSB nibble first.
//                The carry between nibbles is held in a register.
//  Revision    : 1.0  initial release
// ============================================================================
module multiword_add_seq #(
    parameter int WIDTH = 16
) (
    input  wire                clk,
    input  wire                rst_n,
    multiword_add_seq_if.slave bus
);

    localparam int c_NIB  = WIDTH / 4;
    localparam int c_IDXW = (c_NIB > 1) ? $clog2(c_NIB) : 1;
    localparam logic [c_IDXW-1:0] c_IDX_LAST = c_IDXW'(c_NIB - 1);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_RUN  = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic [WIDTH-1:0]  r_res;
    logic              r_carry;
    logic              r_cout;
    logic [c_IDXW-1:0] r_idx;
    logic [c_IDXW+1:0] w_bit;
    logic              w_idle;
    logic              w_run;
    logic              w_last;
    logic              w_accept;

    // Bit offset of the nibble being processed this cycle
    assign w_bit    = {r_idx, 2'b00};
    assign w_idle   = (r_state == c_ST_IDLE);
    assign w_run    = (r_state == c_ST_RUN);
    assign w_last   = (r_idx == c_IDX_LAST);
    assign w_accept = w_idle & bus.in_valid;

    // Ready is masked by reset so nothing looks acceptable while held in reset
    assign bus.in_ready  = w_idle & rst_n;
    assign bus.busy      = ~w_idle;
    assign bus.out_valid = (r_state == c_ST_DONE);
    assign bus.out_sum   = r_res;
    assign bus.out_cout  = r_cout;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and nibble-adder drive; adder inputs idle at zero outside RUN
    always_comb begin
        w_state_nxt = r_state;
        bus.add_a   = 4'h0;
        bus.add_b   = 4'h0;
        bus.add_cin = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (bus.in_valid) begin
                    w_state_nxt = c_ST_RUN;
                end
            end
            c_ST_RUN: begin
                bus.add_a   = r_a[w_bit +: 4];
                bus.add_b   = r_b[w_bit +: 4];
                bus.add_cin = r_carry;
                if (w_last) begin
                    w_state_nxt = c_ST_DONE;
                end
            end
            c_ST_DONE: begin
                if (bus.out_ready) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // Operand capture, per-nibble result write-back and carry chaining
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_idx   <= '0;
        end else if (w_accept) begin
            r_a     <= bus.in_a;
            r_b     <= bus.in_b;
            r_carry <= bus.in_cin;
            r_idx   <= '0;
        end else if (w_run) begin
            r_res[w_bit +: 4] <= bus.add_sum;
            r_carry           <= bus.add_cout;
            if (w_last) begin
                r_cout <= bus.add_cout;
            end else begin
                r_idx <= r_idx + c_IDXW'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_multiword_add_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multiword_add_seq
//  Description : Self-checking bench for multiword_add_seq at WIDTH=16 and
//                WIDTH=8, each paired with a behavioural 4-bit adder.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_multiword_add_seq;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    multiword_add_seq_if #(.WIDTH(16)) b16 ();
    multiword_add_seq_if #(.WIDTH(8))  b8 ();

    multiword_add_seq #(.WIDTH(16)) u_dut16 (.clk(clk), .rst_n(rst_n), .bus(b16));
    multiword_add_seq #(.WIDTH(8))  u_dut8  (.clk(clk), .rst_n(rst_n), .bus(b8));

    // Stand-in for the team's combinational 4-bit ripple-carry adder
    assign {b16.add_cout, b16.add_sum} = {1'b0, b16.add_a} + {1'b0, b16.add_b} + {4'h0, b16.add_cin};
    assign {b8.add_cout,  b8.add_sum}  = {1'b0, b8.add_a}  + {1'b0, b8.add_b}  + {4'h0, b8.add_cin};

    // One WIDTH=16 transaction; records the adder drive seen in each RUN cycle
    task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic cin,
                        output logic [15:0] s, output logic co, output int lat,
                        output logic [15:0] anib, output logic [15:0] bnib,
                        output logic [3:0] cseq);
        s = '0; co = 1'b0; lat = -1; anib = '0; bnib = '0; cseq = '0;
        b16.in_a = a; b16.in_b = b; b16.in_cin = cin; b16.in_valid = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            b16.in_valid = 1'b0;
            if (n <= 4) begin
                anib[4*(n-1) +: 4] = b16.add_a;
                bnib[4*(n-1) +: 4] = b16.add_b;
                cseq[n-1]          = b16.add_cin;
            end
            if (b16.out_valid) begin
                lat = n; s = b16.out_sum; co = b16.out_cout;
                break;
            end
        end
        @(negedge clk);
    endtask

    // One WIDTH=8 transaction
    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                       output logic [7:0] s, output logic co, output int lat,
                       output logic [7:0] anib, output logic [1:0] cseq);
        s = '0; co = 1'b0; lat = -1; anib = '0; cseq = '0;
        b8.in_a = a; b8.in_b = b; b8.in_cin = cin; b8.in_valid = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            b8.in_valid = 1'b0;
            if (n <= 2) begin
                anib[4*(n-1) +: 4] = b8.add_a;
                cseq[n-1]          = b8.add_cin;
            end
            if (b8.out_valid) begin
                lat = n; s = b8.out_sum; co = b8.out_cout;
                break;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (b16.in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready_low: got %b want 0", b16.in_ready); end
        checks++; if (b8.in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready8_low: got %b want 0", b8.in_ready); end
        checks++; if (b16.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", b16.out_valid); end
        checks++; if (b16.out_sum !== 16'h0) begin errors++; $display("FAIL rst_out_sum: got %h want 0", b16.out_sum); end
        checks++; if (b16.out_cout !== 1'b0) begin errors++; $display("FAIL rst_out_cout: got %b want 0", b16.out_cout); end
        checks++; if (b16.busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", b16.busy); end
        checks++; if ({b16.add_a, b16.add_b, b16.add_cin} !== 9'h0) begin errors++; $display("FAIL rst_add_drive: got %h want 0", {b16.add_a, b16.add_b, b16.add_cin}); end
        rst_n = 1'b1;
        #1;
        checks++; if (b16.in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready_high: got %b want 1", b16.in_ready); end
        @(negedge clk);
        checks++; if (b16.busy !== 1'b0 || b16.out_valid !== 1'b0) begin errors++; $display("FAIL rst_idle_after: busy=%b out_valid=%b want 0 0", b16.busy, b16.out_valid); end
    endtask

    task automatic test_basic();
        logic [15:0] s, an, bn; logic co; int lat; logic [3:0] cs;
        op16(16'h1234, 16'h4321, 1'b0, s, co, lat, an, bn, cs);
        checks++; if (s !== 16'h5555) begin errors++; $display("FAIL basic_sum: got %h want 5555", s); end
        checks++; if (co !== 1'b0) begin errors++; $display("FAIL basic_cout: got %b want 0", co); end
        checks++; if (lat !== 5) begin errors++; $display("FAIL basic_latency: got %0d want 5", lat); end
        checks++; if (an !== 16'h1234) begin errors++; $display("FAIL basic_add_a_seq: got %h want 1234", an); end
        checks++; if (bn !== 16'h4321) begin errors++; $display("FAIL basic_add_b_seq: got %h want 4321", bn); end
        checks++; if (b16.in_ready !== 1'b1 || b16.out_valid !== 1'b0) begin errors++; $display("FAIL basic_idle_after: in_ready=%b out_valid=%b want 1 0", b16.in_ready, b16.out_valid); end
    endtask

    task automatic test_carry();
        logic [15:0] s, an, bn; logic co; int lat; logic [3:0] cs;
        op16(16'hFFFF, 16'h0001, 1'b0, s, co, lat, an, bn, cs);
        checks++; if ({co, s} !== 17'h10000) begin errors++; $display("FAIL ripple_result: got %b_%h want 1_0000", co, s); end
        checks++; if (cs !== 4'b1110) begin errors++; $display("FAIL ripple_add_cin_seq: got %b want 1110", cs); end
        op16(16'hFFFF, 16'h0000, 1'b1, s, co, lat, an, bn, cs);
        checks++; if ({co, s} !== 17'h10000) begin errors++; $display("FAIL cin_only_result: got %b_%h want 1_0000", co, s); end
        checks++; if (cs !== 4'b1111) begin errors++; $display("FAIL cin_only_add_cin_seq: got %b want 1111", cs); end
        op16(16'h8000, 16'h8000, 1'b0, s, co, lat, an, bn, cs);
        checks++; if ({co, s} !== 17'h10000) begin errors++; $display("FAIL msb_carry_result: got %b_%h want 1_0000", co, s); end
    endtask

    task automatic test_backpressure();
        logic [16:0] ref_v;
        ref_v = {1'b0, 16'h1111} + {1'b0, 16'h2222} + 17'd1;
        b16.out_ready = 1'b0;
        b16.in_a = 16'h1111; b16.in_b = 16'h2222; b16.in_cin = 1'b1; b16.in_valid = 1'b1;
        for (int n = 0; n < 20 && !b16.out_valid; n++) begin
            @(negedge clk);
            b16.in_valid = 1'($urandom_range(0, 1));
            b16.in_a = 16'($urandom); b16.in_b = 16'($urandom); b16.in_cin = 1'($urandom_range(0, 1));
        end
        checks++; if (b16.out_valid !== 1'b1) begin errors++; $display("FAIL bp_reach_done: out_valid got %b want 1", b16.out_valid); end
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            checks++; if (b16.out_valid !== 1'b1 || b16.in_ready !== 1'b0) begin errors++; $display("FAIL bp_hold_flags: out_valid=%b in_ready=%b want 1 0", b16.out_valid, b16.in_ready); end
            checks++; if ({b16.out_cout, b16.out_sum} !== ref_v) begin errors++; $display("FAIL bp_hold_result: got %b_%h want %b_%h", b16.out_cout, b16.out_sum, ref_v[16], ref_v[15:0]); end
            b16.in_valid = 1'b1;
            b16.in_a = 16'($urandom); b16.in_b = 16'($urandom);
        end
        b16.in_valid = 1'b0;
        b16.out_ready = 1'b1;
        @(negedge clk);
        checks++; if (b16.out_valid !== 1'b0 || b16.in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_idle: out_valid=%b in_ready=%b want 0 1", b16.out_valid, b16.in_ready); end
        checks++; if ({b16.out_cout, b16.out_sum} !== ref_v) begin errors++; $display("FAIL bp_release_result_kept: got %b_%h want %b_%h", b16.out_cout, b16.out_sum, ref_v[16], ref_v[15:0]); end
    endtask

    task automatic test_reset_mid();
        logic [15:0] s, an, bn; logic co; int lat; logic [3:0] cs;
        b16.in_a = 16'hF7F7; b16.in_b = 16'h7171; b16.in_cin = 1'b1; b16.in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            b16.in_valid = 1'b0;
        end
        checks++; if (b16.add_a !== 4'h7) begin errors++; $display("FAIL rmid_at_idx2: add_a got %h want 7", b16.add_a); end
        rst_n = 1'b0;
        @(negedge clk);
        checks++; if (b16.out_valid !== 1'b0 || b16.busy !== 1'b0 || b16.in_ready !== 1'b0) begin errors++; $display("FAIL rmid_state: out_valid=%b busy=%b in_ready=%b want 0 0 0", b16.out_valid, b16.busy, b16.in_ready); end
        checks++; if (b16.out_sum !== 16'h0 || b16.out_cout !== 1'b0) begin errors++; $display("FAIL rmid_result_cleared: got %b_%h want 0_0000", b16.out_cout, b16.out_sum); end
        rst_n = 1'b1;
        #1;
        checks++; if (b16.in_ready !== 1'b1) begin errors++; $display("FAIL rmid_in_ready: got %b want 1", b16.in_ready); end
        op16(16'h0001, 16'h0001, 1'b0, s, co, lat, an, bn, cs);
        checks++; if ({co, s} !== 17'h00002) begin errors++; $display("FAIL rmid_next_op: got %b_%h want 0_0002", co, s); end
    endtask

    task automatic test_back_to_back();
        int acc1 = -1, acc2 = -1, ov1 = -1, ov2 = -1;
        logic [7:0] s1 = '0, s2 = '0; logic c1 = 1'b0, c2 = 1'b0;
        b8.out_ready = 1'b1;
        b8.in_a = 8'hA5; b8.in_b = 8'h5B; b8.in_cin = 1'b0; b8.in_valid = 1'b1;
        for (int cyc = 0; cyc < 30; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (b8.out_valid) begin
                if (ov1 < 0) begin ov1 = cyc; s1 = b8.out_sum; c1 = b8.out_cout; end
                else if (ov2 < 0) begin ov2 = cyc; s2 = b8.out_sum; c2 = b8.out_cout; end
            end
            if (acc2 >= 0) b8.in_valid = 1'b0;
            if (b8.in_valid && b8.in_ready) begin
                if (acc1 < 0) acc1 = cyc;
                else if (acc2 < 0) acc2 = cyc;
            end
            if (acc1 >= 0 && acc2 < 0 && cyc > acc1) begin
                b8.in_a = 8'h3C; b8.in_b = 8'h4D; b8.in_cin = 1'b1;
            end
        end
        checks++; if ({c1, s1} !== 9'h100) begin errors++; $display("FAIL b2b_first_result: got %b_%h want 1_00", c1, s1); end
        checks++; if (ov1 - acc1 !== 3) begin errors++; $display("FAIL b2b_first_latency: got %0d want 3", ov1 - acc1); end
        checks++; if (acc2 - acc1 !== 4) begin errors++; $display("FAIL b2b_interval: got %0d want 4", acc2 - acc1); end
        checks++; if ({c2, s2} !== 9'h08A) begin errors++; $display("FAIL b2b_second_result: got %b_%h want 0_8a", c2, s2); end
        checks++; if (ov2 - acc2 !== 3) begin errors++; $display("FAIL b2b_second_latency: got %0d want 3", ov2 - acc2); end
    endtask

    task automatic test_random8();
        logic [7:0] a, b, s, an; logic cin, co; int lat; logic [1:0] cs, cs_exp;
        logic [8:0] ref_v;
        b8.out_ready = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom_range(0, 1));
            ref_v = 9'(int'(a) + int'(b) + int'(cin));
            for (int k = 0; k < 2; k++) begin
                int m;
                m = (1 << (4*k)) - 1;
                cs_exp[k] = 1'(((int'(a) & m) + (int'(b) & m) + int'(cin)) >> (4*k));
            end
            op8(a, b, cin, s, co, lat, an, cs);
            checks++; if ({co, s} !== ref_v) begin errors++; $display("FAIL rand8_result: %h+%h+%b got %b_%h want %b_%h", a, b, cin, co, s, ref_v[8], ref_v[7:0]); end
            checks++; if (lat !== 3) begin errors++; $display("FAIL rand8_latency: got %0d want 3", lat); end
            checks++; if (an !== a || cs !== cs_exp) begin errors++; $display("FAIL rand8_adder_drive: add_a %h cin %b want %h %b", an, cs, a, cs_exp); end
        end
    endtask

    task automatic test_random16();
        logic [15:0] a, b, s, an, bn; logic cin, co; int lat; logic [3:0] cs;
        logic [16:0] ref_v;
        b16.out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom_range(0, 1));
            ref_v = 17'(int'(a) + int'(b) + int'(cin));
            op16(a, b, cin, s, co, lat, an, bn, cs);
            checks++; if ({co, s} !== ref_v || lat !== 5) begin errors++; $display("FAIL rand16_result: %h+%h+%b got %b_%h lat %0d want %b_%h lat 5", a, b, cin, co, s, lat, ref_v[16], ref_v[15:0]); end
        end
    endtask

    initial begin
        b16.in_valid = 1'b0; b16.in_a = '0; b16.in_b = '0; b16.in_cin = 1'b0; b16.out_ready = 1'b1;
        b8.in_valid  = 1'b0; b8.in_a  = '0; b8.in_b  = '0; b8.in_cin  = 1'b0; b8.out_ready  = 1'b1;
        test_reset();
        test_basic();
        test_carry();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        test_random8();
        test_random16();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
